// File: rtl/approx_mult_pipe_pkg.sv
// Shared defaults and the bit-exact golden model of the approximate multiplier.
// The model is written for any operand width up to MAX_W.
package approx_mult_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_TRUNC_COLS = 5;
    localparam int DEF_MASK_COLS  = 7;
    localparam int DEF_TAG_W      = 4;
    localparam int DEF_CNT_W      = 16;

    localparam int MAX_W = 16;
    localparam int MAX_P = 2 * MAX_W;

    // Column-by-column reference: OR region, maskable region, then exact ripple.
    function automatic logic [MAX_P-1:0] approx_mult_ref(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             approx,
        input logic             mask_x,
        input int               width,
        input int               trunc_cols,
        input int               mask_cols
    );
        logic [MAX_P-1:0] s;
        logic [MAX_P-1:0] c;
        logic [MAX_P-1:0] r;
        logic [MAX_P-1:0] pmask;
        logic             cy;
        logic             sk;
        logic             ck;
        s  = '0;
        c  = '0;
        r  = '0;
        cy = 1'b0;
        if (width >= MAX_W) begin
            pmask = '1;
        end else begin
            pmask = (MAX_P'(1) << (2 * width)) - MAX_P'(1);
        end
        for (int i = 0; i < width; i++) begin
            if (b[i]) begin
                if ((i % 2) == 0) begin
                    s = s + (MAX_P'(a) << i);
                end else begin
                    c = c + (MAX_P'(a) << i);
                end
            end
        end
        s = s & pmask;
        c = c & pmask;
        if (!approx) begin
            r = (s + c) & pmask;
        end else begin
            for (int k = 0; k < 2 * width; k++) begin
                sk = s[k];
                ck = c[k];
                if (k < trunc_cols) begin
                    r[k] = sk | ck;
                end else if ((k < trunc_cols + mask_cols) && !mask_x) begin
                    r[k] = (sk | ck) ^ cy;
                    cy   = (sk | ck) & cy;
                end else begin
                    r[k] = sk ^ ck ^ cy;
                    cy   = (sk & ck) | (cy & (sk ^ ck));
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle of the approximate multiplier pipeline.
// The master side is the producer/consumer; the slave side is the multiplier.
interface approx_mult_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_approx;
    logic               in_mask_x;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_product;
    logic [TAG_W-1:0]   out_tag;
    logic               out_approx;

    modport master (
        output in_valid, in_a, in_b, in_approx, in_mask_x, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag, out_approx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_approx, in_mask_x, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag, out_approx
    );
endinterface

// File: rtl/approx_mult_pipe_col_adder.sv
// Final S+C column adder with OR-only, carry-maskable and exact column regions.
// Purely combinational; exact mode bypasses the column chain with a plain add.
module approx_col_adder #(
    parameter int WIDTH      = 8,
    parameter int TRUNC_COLS = 5,
    parameter int MASK_COLS  = 7,
    localparam int P         = 2 * WIDTH
) (
    input  logic [P-1:0] s,
    input  logic [P-1:0] c,
    input  logic         approx,
    input  logic         mask_x,
    output logic [P-1:0] sum
);

    logic [P-1:0] exact_sum;
    logic [P-1:0] approx_sum;
    logic [P-1:0] cy;

    assign exact_sum = s + c;
    assign cy[0]     = 1'b0;

    // cy[k] is the carry into column k; the OR region forces it to zero.
    for (genvar k = 0; k < P; k++) begin : g_col
        if (k < TRUNC_COLS) begin : g_or
            assign approx_sum[k] = (s[k] | c[k]) ^ cy[k];
            if (k < P - 1) begin : g_carry
                assign cy[k+1] = 1'b0;
            end
        end else if (k < TRUNC_COLS + MASK_COLS) begin : g_mask
            assign approx_sum[k] = mask_x ? (s[k] ^ c[k] ^ cy[k])
                                          : ((s[k] | c[k]) ^ cy[k]);
            if (k < P - 1) begin : g_carry
                assign cy[k+1] = mask_x ? ((s[k] & c[k]) | (cy[k] & (s[k] ^ c[k])))
                                        : ((s[k] | c[k]) & cy[k]);
            end
        end else begin : g_exact
            assign approx_sum[k] = s[k] ^ c[k] ^ cy[k];
            if (k < P - 1) begin : g_carry
                assign cy[k+1] = (s[k] & c[k]) | (cy[k] & (s[k] ^ c[k]));
            end
        end
    end

    assign sum = approx ? approx_sum : exact_sum;

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined accuracy-controllable WIDTH x WIDTH multiplier with a
// global-stall valid/ready handshake and a saturating approximate-op counter.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TRUNC_COLS = DEF_TRUNC_COLS,
    parameter int MASK_COLS  = DEF_MASK_COLS,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int CNT_W      = DEF_CNT_W,
    localparam int P         = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    approx_mult_pipe_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] approx_cnt
);

    logic             adv;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_approx;
    logic             s1_mask;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [P-1:0]     s2_s;
    logic [P-1:0]     s2_c;
    logic             s2_approx;
    logic             s2_mask;
    logic [TAG_W-1:0] s2_tag;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;

    logic             out_valid_q;
    logic [P-1:0]     out_product_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_approx_q;

    logic [P-1:0]     s_comb;
    logic [P-1:0]     c_comb;
    logic [P-1:0]     col_sum;
    logic [MAX_P-1:0] ref_full;
    logic [CNT_W-1:0] cnt_q;

    // One stall signal freezes every stage whenever the result is not taken.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a      <= bus.in_a;
            s1_b      <= bus.in_b;
            s1_approx <= bus.in_approx;
            s1_mask   <= bus.in_mask_x;
            s1_tag    <= bus.in_tag;
            s2_s      <= s_comb;
            s2_c      <= c_comb;
            s2_approx <= s1_approx;
            s2_mask   <= s1_mask;
            s2_tag    <= s1_tag;
            s2_a      <= s1_a;
            s2_b      <= s1_b;
        end
    end

    // Even-row and odd-row partial products are summed separately.
    always_comb begin
        s_comb = '0;
        c_comb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_b[i]) begin
                if ((i % 2) == 0) begin
                    s_comb = s_comb + (P'(s1_a) << i);
                end else begin
                    c_comb = c_comb + (P'(s1_a) << i);
                end
            end
        end
    end

    approx_col_adder #(
        .WIDTH      (WIDTH),
        .TRUNC_COLS (TRUNC_COLS),
        .MASK_COLS  (MASK_COLS)
    ) u_col_adder (
        .s      (s2_s),
        .c      (s2_c),
        .approx (s2_approx),
        .mask_x (s2_mask),
        .sum    (col_sum)
    );

    // Output data only changes when a real result moves in, so bubbles keep the last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_product_q <= '0;
            out_tag_q     <= '0;
            out_approx_q  <= 1'b0;
        end else if (adv && s2_valid) begin
            out_product_q <= col_sum;
            out_tag_q     <= s2_tag;
            out_approx_q  <= s2_approx;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_approx  = out_approx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (bus.in_valid && adv && bus.in_approx && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign approx_cnt = cnt_q;

    always_comb begin
        ref_full = approx_mult_ref(MAX_W'(s2_a), MAX_W'(s2_b), s2_approx, s2_mask,
                                   WIDTH, TRUNC_COLS, MASK_COLS);
    end

    // The column adder must agree with the golden model for every result it commits.
    always_ff @(posedge clk) begin
        if (rst_n && adv && s2_valid) begin
            assert (MAX_P'(col_sum) == ref_full);
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed and stalled-stream bench for approx_mult_pipe, plus a CNT_W=4
// instance for counter saturation and clear priority.
module tb_approx_mult_pipe;
    import approx_mult_pkg::*;

    typedef struct {
        logic [15:0] prod;
        logic [3:0]  tag;
        logic        approx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_clr;
    logic        cnt_clr_sat;
    logic [15:0] approx_cnt;
    logic [3:0]  approx_cnt_sat;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    approx_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) bus ();
    approx_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) bus_sat ();

    approx_mult_pipe #(
        .WIDTH(8), .TRUNC_COLS(5), .MASK_COLS(7), .TAG_W(4), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .approx_cnt (approx_cnt)
    );

    approx_mult_pipe #(
        .WIDTH(8), .TRUNC_COLS(5), .MASK_COLS(7), .TAG_W(4), .CNT_W(4)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_sat),
        .cnt_clr    (cnt_clr_sat),
        .approx_cnt (approx_cnt_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic approx, input logic mask_x, input logic [3:0] tag);
        int waited;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_approx = approx;
        bus.in_mask_x = mask_x;
        bus.in_tag    = tag;
        bus.in_valid  = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        if (approx) exp_cnt++;
        bus.in_valid = 1'b0;
    endtask

    // Single op on an idle pipe: nothing after one edge, result after two.
    task automatic runDirected(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic approx, input logic mask_x, input logic [3:0] tag,
                               input logic [15:0] exp_prod);
        applyStimulus(a, b, approx, mask_x, tag);
        tick();
        checkOutput({name, "_lat1"}, 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({name, "_prod"}, 32'(bus.out_product), 32'(exp_prod));
        checkOutput({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        checkOutput({name, "_mode"}, 32'(bus.out_approx), 32'(approx));
        tick();
    endtask

    initial begin
        exp_t        exp_q[$];
        exp_t        e;
        logic [31:0] r;
        logic [7:0]  cur_a;
        logic [7:0]  cur_b;
        logic        cur_x;
        logic        cur_m;
        logic [3:0]  cur_t;
        logic        accept;
        logic        stalled;
        logic [15:0] held_p;
        logic [3:0]  held_t;
        logic        held_x;
        int          sent;
        int          recvd;
        int          cyc;

        rst_n             = 1'b0;
        cnt_clr           = 1'b0;
        cnt_clr_sat       = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_a          = '0;
        bus.in_b          = '0;
        bus.in_approx     = 1'b0;
        bus.in_mask_x     = 1'b0;
        bus.in_tag        = '0;
        bus.out_ready     = 1'b1;
        bus_sat.in_valid  = 1'b0;
        bus_sat.in_a      = '0;
        bus_sat.in_b      = '0;
        bus_sat.in_approx = 1'b0;
        bus_sat.in_mask_x = 1'b0;
        bus_sat.in_tag    = '0;
        bus_sat.out_ready = 1'b1;
        cur_a = '0; cur_b = '0; cur_x = 1'b0; cur_m = 1'b0; cur_t = '0;

        tick();
        tick();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_product", 32'(bus.out_product), 32'd0);
        checkOutput("rst_tag", 32'(bus.out_tag), 32'd0);
        checkOutput("rst_approx", 32'(bus.out_approx), 32'd0);
        checkOutput("rst_cnt", 32'(approx_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        runDirected("exact_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 4'h1, 16'hFE01);
        checkOutput("cnt_after_exact", 32'(approx_cnt), 32'd0);
        runDirected("apx_ff_m0", 8'hFF, 8'hFF, 1'b1, 1'b0, 4'h2, 16'hFDFF);
        runDirected("apx_ff_m1", 8'hFF, 8'hFF, 1'b1, 1'b1, 4'h3, 16'hFDFF);
        checkOutput("cnt_after_ff", 32'(approx_cnt), 32'd2);
        runDirected("apx_60_m1", 8'h60, 8'h03, 1'b1, 1'b1, 4'h4, 16'h0120);
        runDirected("apx_60_m0", 8'h60, 8'h03, 1'b1, 1'b0, 4'h5, 16'h00E0);
        runDirected("apx_03", 8'h03, 8'h03, 1'b1, 1'b1, 4'h6, 16'h0007);
        checkOutput("cnt_after_dir", 32'(approx_cnt), 32'd5);

        // Random stream with a random consumer; one op offered at a time.
        sent    = 0;
        recvd   = 0;
        cyc     = 0;
        stalled = 1'b0;
        held_p  = '0;
        held_t  = '0;
        held_x  = 1'b0;
        while (recvd < 20 && cyc < 500) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (!bus.in_valid && sent < 20) begin
                cur_a = 8'($urandom);
                cur_b = 8'($urandom);
                cur_x = 1'($urandom_range(0, 1));
                cur_m = 1'($urandom_range(0, 1));
                cur_t = 4'(sent % 16);
                bus.in_a      = cur_a;
                bus.in_b      = cur_b;
                bus.in_approx = cur_x;
                bus.in_mask_x = cur_m;
                bus.in_tag    = cur_t;
                bus.in_valid  = 1'b1;
            end
            #1;
            if (bus.out_valid) begin
                if (stalled) begin
                    checkOutput("stall_prod", 32'(bus.out_product), 32'(held_p));
                    checkOutput("stall_tag", 32'(bus.out_tag), 32'(held_t));
                    checkOutput("stall_mode", 32'(bus.out_approx), 32'(held_x));
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("stream_extra", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("stream_prod", 32'(bus.out_product), 32'(e.prod));
                        checkOutput("stream_tag", 32'(bus.out_tag), 32'(e.tag));
                        checkOutput("stream_mode", 32'(bus.out_approx), 32'(e.approx));
                        recvd++;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_p  = bus.out_product;
                    held_t  = bus.out_tag;
                    held_x  = bus.out_approx;
                end
            end else begin
                stalled = 1'b0;
            end
            accept = bus.in_valid && bus.in_ready;
            if (accept) begin
                r        = approx_mult_ref(16'(cur_a), 16'(cur_b), cur_x, cur_m, 8, 5, 7);
                e.prod   = r[15:0];
                e.tag    = cur_t;
                e.approx = cur_x;
                exp_q.push_back(e);
                sent++;
                if (cur_x) exp_cnt++;
            end
            tick();
            if (accept) bus.in_valid = 1'b0;
            cyc++;
        end
        checkOutput("stream_count", 32'(recvd), 32'd20);
        checkOutput("stream_cnt", 32'(approx_cnt), 32'(exp_cnt));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
        tick();
        tick();

        // Two ops in flight when reset hits: neither may ever appear.
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 4'hA);
        applyStimulus(8'h56, 8'h78, 1'b1, 1'b1, 4'hB);
        rst_n = 1'b0;
        #1;
        checkOutput("rstfl_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("rstfl_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstfl_cnt", 32'(approx_cnt), 32'd0);
        checkOutput("rstfl_prod", 32'(bus.out_product), 32'd0);
        checkOutput("rstfl_tag", 32'(bus.out_tag), 32'd0);
        rst_n   = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstfl_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Saturation on the 4-bit counter instance.
        bus_sat.in_a      = 8'h01;
        bus_sat.in_b      = 8'h01;
        bus_sat.in_approx = 1'b1;
        bus_sat.in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        checkOutput("sat_cnt", 32'(approx_cnt_sat), 32'hF);
        cnt_clr_sat = 1'b1;
        tick();
        checkOutput("clr_wins", 32'(approx_cnt_sat), 32'd0);
        cnt_clr_sat = 1'b0;
        tick();
        checkOutput("cnt_after_clr", 32'(approx_cnt_sat), 32'd1);
        bus_sat.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
